// File: rtl/bus_cycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_cycle_pkg
// Description : State encoding, packed-parameter slice helper and the default
//               68000 board region map for bus_cycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================

// Select slice idx of a packed per-region vector whose slices are w bits wide.
`define BCC_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package bus_cycle_pkg;

    // Bus cycle sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } bus_state_t;

    localparam int c_DEFAULT_REGIONS    = 4;
    localparam int c_DEFAULT_ADDR_WIDTH = 24;
    localparam int c_DEFAULT_WAIT_WIDTH = 4;

    // Region 0 PROM, region 1 SRAM, regions 2/3 peripheral pages.
    localparam logic [c_DEFAULT_REGIONS*c_DEFAULT_ADDR_WIDTH-1:0] c_DEFAULT_BASE =
        {24'hE10000, 24'hE00000, 24'h100000, 24'h000000};
    localparam logic [c_DEFAULT_REGIONS*c_DEFAULT_ADDR_WIDTH-1:0] c_DEFAULT_MASK =
        {24'hFF0000, 24'hFF0000, 24'hF00000, 24'hF00000};
    localparam logic [c_DEFAULT_REGIONS*c_DEFAULT_WAIT_WIDTH-1:0] c_DEFAULT_WAIT =
        {4'd8, 4'd4, 4'd0, 4'd2};

endpackage

`default_nettype wire

// File: rtl/bus_cycle_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : bus_cycle_controller_if
// Description : CPU-side strobes/address and memory-side selects/handshake of
//               the bus cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_cycle_controller_if
    import bus_cycle_pkg::*;
#(
    parameter int NUM_REGIONS = c_DEFAULT_REGIONS,
    parameter int ADDR_WIDTH  = c_DEFAULT_ADDR_WIDTH
);
    logic                   RUN_IN;
    logic                   AS_IN;
    logic                   WR_IN;
    logic                   UDS_IN;
    logic                   LDS_IN;
    logic [ADDR_WIDTH-1:0]  ADDR_IN;
    logic                   STEPEN_IN;
    logic                   STEP_IN;
    logic [NUM_REGIONS-1:0] CS;
    logic                   OE;
    logic                   UWE;
    logic                   LWE;
    logic                   DTACK;
    logic                   BERR;
    logic                   STEP_WAIT;

    // CPU / board side.
    modport master (
        output RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, ADDR_IN, STEPEN_IN, STEP_IN,
        input  CS, OE, UWE, LWE, DTACK, BERR, STEP_WAIT
    );

    // Controller side.
    modport slave (
        input  RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, ADDR_IN, STEPEN_IN, STEP_IN,
        output CS, OE, UWE, LWE, DTACK, BERR, STEP_WAIT
    );
endinterface

`default_nettype wire

// File: rtl/bus_cycle_controller_step_sync.sv
`default_nettype none
// ============================================================================
// Module      : step_sync
// Description : Two-flop synchroniser for the asynchronous step button plus an
//               edge register giving a one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module step_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_step,
    output wire logic o_pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Bring the button into the clock domain and remember the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_step;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;
endmodule

`default_nettype wire

// File: rtl/bus_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_controller
// Description : 68000 bus glue: region decode, registered chip selects and
//               byte-lane strobes, wait states, BERR watchdog, read-only
//               protection and single-step DTACK hold.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_controller
    import bus_cycle_pkg::*;
#(
    parameter int                                   NUM_REGIONS  = c_DEFAULT_REGIONS,
    parameter int                                   ADDR_WIDTH   = c_DEFAULT_ADDR_WIDTH,
    parameter int                                   WAIT_WIDTH   = c_DEFAULT_WAIT_WIDTH,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0]    REGION_BASE  = c_DEFAULT_BASE,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0]    REGION_MASK  = c_DEFAULT_MASK,
    parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0]    REGION_WAIT  = c_DEFAULT_WAIT,
    parameter logic [NUM_REGIONS-1:0]               REGION_RO    = '0,
    parameter int                                   BERR_TIMEOUT = 64
) (
    input wire logic               CPUCLK_IN,
    input wire logic               RESET_n,
    bus_cycle_controller_if.slave  bus
);
    localparam int                c_WD_W    = $clog2(BERR_TIMEOUT + 1);
    // The edge that would take the watchdog to BERR_TIMEOUT raises BERR instead.
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(BERR_TIMEOUT - 1);

    logic [NUM_REGIONS-1:0] w_hit;
    logic [NUM_REGIONS-1:0] w_sel_cs;
    logic [WAIT_WIDTH-1:0]  w_sel_wait;
    logic                   w_sel_ro;
    logic                   w_step_pulse;

    bus_state_t             r_state;
    logic [WAIT_WIDTH-1:0]  r_wait_cnt;
    logic [c_WD_W-1:0]      r_wdog;
    logic                   r_armed;
    logic [NUM_REGIONS-1:0] r_cs;
    logic                   r_oe;
    logic                   r_uwe;
    logic                   r_lwe;
    logic                   r_dtack;
    logic                   r_berr;
    logic                   r_step_wait;

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_decode
            assign w_hit[gi] = (bus.ADDR_IN & `BCC_SLICE(REGION_MASK, gi, ADDR_WIDTH))
                               == `BCC_SLICE(REGION_BASE, gi, ADDR_WIDTH);
        end
    endgenerate

    // Priority select: scanning downwards lets the lowest hitting index win.
    always_comb begin
        w_sel_cs   = '0;
        w_sel_wait = '0;
        w_sel_ro   = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_cs    = '0;
                w_sel_cs[i] = 1'b1;
                w_sel_wait  = `BCC_SLICE(REGION_WAIT, i, WAIT_WIDTH);
                w_sel_ro    = REGION_RO[i];
            end
        end
    end

    step_sync u_step_sync (
        .clk     (CPUCLK_IN),
        .rst_n   (RESET_n),
        .i_step  (bus.STEP_IN),
        .o_pulse (w_step_pulse)
    );

    // Bus cycle sequencer with registered outputs.
    always_ff @(posedge CPUCLK_IN or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_wdog      <= '0;
            r_armed     <= 1'b0;
            r_cs        <= '0;
            r_oe        <= 1'b0;
            r_uwe       <= 1'b0;
            r_lwe       <= 1'b0;
            r_dtack     <= 1'b0;
            r_berr      <= 1'b0;
            r_step_wait <= 1'b0;
        end else begin
            // An AS left asserted across reset must be negated before it counts.
            if (!bus.AS_IN) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.AS_IN && bus.RUN_IN && r_armed) begin
                        r_armed <= 1'b0;
                        if (!(|w_hit) || (bus.WR_IN && w_sel_ro)) begin
                            r_state <= ST_ERR;
                            r_berr  <= 1'b1;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= w_sel_wait;
                            r_wdog     <= '0;
                            r_cs       <= w_sel_cs;
                            r_oe       <= ~bus.WR_IN;
                            r_uwe      <= bus.WR_IN & bus.UDS_IN;
                            r_lwe      <= bus.WR_IN & bus.LDS_IN;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.AS_IN) begin
                        r_state     <= ST_IDLE;
                        r_cs        <= '0;
                        r_oe        <= 1'b0;
                        r_uwe       <= 1'b0;
                        r_lwe       <= 1'b0;
                        r_step_wait <= 1'b0;
                    end else if (r_wait_cnt == '0 &&
                                 (!bus.STEPEN_IN || (r_step_wait && w_step_pulse))) begin
                        r_state     <= ST_ACK;
                        r_dtack     <= 1'b1;
                        r_step_wait <= 1'b0;
                    end else if (!bus.STEPEN_IN && r_wdog >= c_WD_LAST) begin
                        r_state     <= ST_ERR;
                        r_berr      <= 1'b1;
                        r_cs        <= '0;
                        r_oe        <= 1'b0;
                        r_uwe       <= 1'b0;
                        r_lwe       <= 1'b0;
                        r_step_wait <= 1'b0;
                    end else begin
                        if (r_wait_cnt != '0) begin
                            r_wait_cnt <= r_wait_cnt - 1'b1;
                        end
                        // Saturate so a long single-step wait cannot wrap past the limit.
                        if (!r_step_wait && r_wdog != '1) begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                        r_step_wait <= (r_wait_cnt == '0) && bus.STEPEN_IN;
                    end
                end
                ST_ACK: begin
                    if (!bus.AS_IN) begin
                        r_state <= ST_IDLE;
                        r_cs    <= '0;
                        r_oe    <= 1'b0;
                        r_uwe   <= 1'b0;
                        r_lwe   <= 1'b0;
                        r_dtack <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (!bus.AS_IN) begin
                        r_state <= ST_IDLE;
                        r_berr  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.CS        = r_cs;
    assign bus.OE        = r_oe;
    assign bus.UWE       = r_uwe;
    assign bus.LWE       = r_lwe;
    assign bus.DTACK     = r_dtack;
    assign bus.BERR      = r_berr;
    assign bus.STEP_WAIT = r_step_wait;
endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_cycle_controller
// Description : Self-checking bench for bus_cycle_controller with a
//               behavioural region-map model and randomized bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_controller;

    localparam int TIMEOUT = 8;

    // Region map under test: region 0 read-only, region 2 overlaps region 3
    // (lower index wins), region 3 has an over-long wait to force timeouts.
    localparam logic [23:0] TB_BASE [4] = '{24'h000000, 24'h100000, 24'h300000, 24'h300000};
    localparam logic [23:0] TB_MASK [4] = '{24'hF00000, 24'hF00000, 24'hFF0000, 24'hF00000};
    localparam int          TB_WAIT [4] = '{1, 2, 0, 15};
    localparam bit          TB_RO   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Observed vector layout: {CS[3:0], OE, UWE, LWE, DTACK, BERR, STEP_WAIT}.
    localparam logic [9:0] V_BERR  = 10'b0000_0000_10;
    localparam logic [9:0] V_DTACK = 10'b0000_0001_00;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [9:0] trace [64];

    bus_cycle_controller_if #(.NUM_REGIONS(4), .ADDR_WIDTH(24)) bus ();

    bus_cycle_controller #(
        .NUM_REGIONS  (4),
        .ADDR_WIDTH   (24),
        .WAIT_WIDTH   (4),
        .REGION_BASE  ({24'h300000, 24'h300000, 24'h100000, 24'h000000}),
        .REGION_MASK  ({24'hF00000, 24'hFF0000, 24'hF00000, 24'hF00000}),
        .REGION_WAIT  ({4'd15, 4'd0, 4'd2, 4'd1}),
        .REGION_RO    (4'b0001),
        .BERR_TIMEOUT (TIMEOUT)
    ) u_dut (
        .CPUCLK_IN (clk),
        .RESET_n   (rst_n),
        .bus       (bus)
    );

    wire [9:0] obs = {bus.CS, bus.OE, bus.UWE, bus.LWE, bus.DTACK, bus.BERR, bus.STEP_WAIT};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after edge k+j of a cycle whose AS is sampled high on
    // edges k..k+h-1 and low on edge k+h (no single-step).
    function automatic logic [9:0] model_out(input logic [23:0] a, input logic wr,
                                             input logic uds, input logic lds,
                                             input int h, input int j);
        int r;
        int res;
        bit ack;
        logic [9:0] act;
        r = -1;
        for (int i = 3; i >= 0; i--)
            if ((a & TB_MASK[i]) == TB_BASE[i]) r = i;
        if (j >= h) return '0;
        if (r < 0) return V_BERR;
        if (wr && TB_RO[r]) return V_BERR;
        act = {4'(1 << r), ~wr, wr & uds, wr & lds, 3'b000};
        if (TB_WAIT[r] + 1 < TIMEOUT) begin
            res = TB_WAIT[r] + 1;
            ack = 1'b1;
        end else begin
            res = TIMEOUT;
            ack = 1'b0;
        end
        if (j < res) return act;
        if (ack) return act | V_DTACK;
        return V_BERR;
    endfunction

    // Run one bus cycle starting just after an edge; records outputs per edge.
    task automatic bus_cycle(input logic [23:0] a, input logic wr, input logic uds,
                             input logic lds, input int h);
        bus.ADDR_IN = a;
        bus.WR_IN   = wr;
        bus.UDS_IN  = uds;
        bus.LDS_IN  = lds;
        bus.AS_IN   = 1'b1;
        for (int j = 0; j <= h; j++) begin
            @(posedge clk); #1;
            trace[j] = obs;
            if (j == h - 1) bus.AS_IN = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.RUN_IN    = 1'b1;
        bus.AS_IN     = 1'b0;
        bus.WR_IN     = 1'b0;
        bus.UDS_IN    = 1'b0;
        bus.LDS_IN    = 1'b0;
        bus.ADDR_IN   = '0;
        bus.STEPEN_IN = 1'b0;
        bus.STEP_IN   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, 10'b0); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, 10'b0); end
    endtask

    task automatic test_read_wait();
        logic [9:0] exp;
        bus_cycle(24'h100040, 1'b0, 1'b1, 1'b1, 6);
        for (int j = 0; j <= 6; j++) begin
            exp = model_out(24'h100040, 1'b0, 1'b1, 1'b1, 6, j);
            n_checks++;
            if (trace[j] !== exp) begin n_fail++; $display("FAIL read_wait[%0d]: got %b expected %b", j, trace[j], exp); end
        end
        n_checks++;
        if (trace[3] !== 10'b0010_1_00_100) begin n_fail++; $display("FAIL read_dtack_edge: got %b expected %b", trace[3], 10'b0010_1_00_100); end
    endtask

    task automatic test_ro_write();
        logic [9:0] exp;
        bus_cycle(24'h000010, 1'b1, 1'b1, 1'b1, 4);
        for (int j = 0; j <= 4; j++) begin
            exp = model_out(24'h000010, 1'b1, 1'b1, 1'b1, 4, j);
            n_checks++;
            if (trace[j] !== exp) begin n_fail++; $display("FAIL ro_write[%0d]: got %b expected %b", j, trace[j], exp); end
        end
    endtask

    task automatic test_unmapped();
        logic [9:0] exp;
        bus_cycle(24'hF00000, 1'b0, 1'b1, 1'b0, 5);
        for (int j = 0; j <= 5; j++) begin
            exp = model_out(24'hF00000, 1'b0, 1'b1, 1'b0, 5, j);
            n_checks++;
            if (trace[j] !== exp) begin n_fail++; $display("FAIL unmapped[%0d]: got %b expected %b", j, trace[j], exp); end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] exp;
        bus_cycle(24'h350000, 1'b0, 1'b1, 1'b1, 12);
        for (int j = 0; j <= 12; j++) begin
            exp = model_out(24'h350000, 1'b0, 1'b1, 1'b1, 12, j);
            n_checks++;
            if (trace[j] !== exp) begin n_fail++; $display("FAIL timeout[%0d]: got %b expected %b", j, trace[j], exp); end
        end
    endtask

    task automatic test_step();
        logic [9:0] c_cs;
        logic [9:0] c_hold;
        logic [9:0] c_ack;
        logic [9:0] exp;
        c_cs   = 10'b0100_1_00_000;
        c_hold = 10'b0100_1_00_001;
        c_ack  = 10'b0100_1_00_100;
        bus.STEPEN_IN = 1'b1;
        bus.ADDR_IN   = 24'h300010;
        bus.WR_IN     = 1'b0;
        bus.UDS_IN    = 1'b1;
        bus.LDS_IN    = 1'b1;
        bus.AS_IN     = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== c_cs) begin n_fail++; $display("FAIL step_cs: got %b expected %b", obs, c_cs); end
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== c_hold) begin n_fail++; $display("FAIL step_hold[%0d]: got %b expected %b", i, obs, c_hold); end
        end
        bus.STEP_IN = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            exp = (i < 3) ? c_hold : c_ack;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL step_press[%0d]: got %b expected %b", i, obs, exp); end
        end
        // A second press while acknowledged must change nothing.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== c_ack) begin n_fail++; $display("FAIL step_second[%0d]: got %b expected %b", i, obs, c_ack); end
            if (i == 2) bus.STEP_IN = 1'b0;
            if (i == 5) bus.STEP_IN = 1'b1;
        end
        bus.AS_IN   = 1'b0;
        bus.STEP_IN = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 10'b0) begin n_fail++; $display("FAIL step_release: got %b expected %b", obs, 10'b0); end
        // Next cycle must hold again: the press seen in ACK was not queued.
        bus.AS_IN = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== c_cs) begin n_fail++; $display("FAIL step2_cs: got %b expected %b", obs, c_cs); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== c_hold) begin n_fail++; $display("FAIL step2_hold[%0d]: got %b expected %b", i, obs, c_hold); end
        end
        bus.STEPEN_IN = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== c_ack) begin n_fail++; $display("FAIL step2_release_ack: got %b expected %b", obs, c_ack); end
        bus.AS_IN = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 10'b0) begin n_fail++; $display("FAIL step2_idle: got %b expected %b", obs, 10'b0); end
    endtask

    task automatic test_run_block();
        logic [9:0] exp;
        bus.RUN_IN  = 1'b0;
        bus.ADDR_IN = 24'h100000;
        bus.WR_IN   = 1'b0;
        bus.AS_IN   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== 10'b0) begin n_fail++; $display("FAIL run_blocked[%0d]: got %b expected %b", i, obs, 10'b0); end
        end
        bus.AS_IN = 1'b0;
        @(posedge clk); #1;
        bus.RUN_IN = 1'b1;
        // RUN dropping mid-cycle must not disturb the cycle.
        bus.ADDR_IN = 24'h100100;
        bus.WR_IN   = 1'b1;
        bus.UDS_IN  = 1'b1;
        bus.LDS_IN  = 1'b0;
        bus.AS_IN   = 1'b1;
        for (int j = 0; j <= 7; j++) begin
            @(posedge clk); #1;
            if (j == 0) bus.RUN_IN = 1'b0;
            if (j == 6) bus.AS_IN = 1'b0;
            exp = model_out(24'h100100, 1'b1, 1'b1, 1'b0, 7, j);
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL run_midcycle[%0d]: got %b expected %b", j, obs, exp); end
        end
        bus.RUN_IN = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        bus.ADDR_IN = 24'h350000;
        bus.WR_IN   = 1'b0;
        bus.AS_IN   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 10'b1000_1_00_000) begin n_fail++; $display("FAIL areset_pre: got %b expected %b", obs, 10'b1000_1_00_000); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 10'b0) begin n_fail++; $display("FAIL areset_async: got %b expected %b", obs, 10'b0); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== 10'b0) begin n_fail++; $display("FAIL areset_stale_as[%0d]: got %b expected %b", i, obs, 10'b0); end
        end
        bus.AS_IN = 1'b0;
        @(posedge clk); #1;
        bus_cycle(24'h100000, 1'b0, 1'b1, 1'b1, 4);
        for (int j = 0; j <= 4; j++) begin
            exp = model_out(24'h100000, 1'b0, 1'b1, 1'b1, 4, j);
            n_checks++;
            if (trace[j] !== exp) begin n_fail++; $display("FAIL areset_fresh[%0d]: got %b expected %b", j, trace[j], exp); end
        end
    endtask

    // Randomized back-to-back cycles with the minimum one-edge AS gap.
    task automatic test_back_to_back();
        logic [23:0] a;
        logic        wr;
        logic        uds;
        logic        lds;
        logic [9:0]  exp;
        int          h;
        int          cat;
        for (int n = 0; n < 40; n++) begin
            cat = $urandom_range(5, 0);
            case (cat)
                0:       a = {4'h0, 20'($urandom)};
                1:       a = {4'h1, 20'($urandom)};
                2:       a = {8'h30, 16'($urandom)};
                3:       a = {4'h3, 4'($urandom_range(15, 1)), 16'($urandom)};
                4:       a = {4'($urandom_range(15, 4)), 20'($urandom)};
                default: a = 24'($urandom);
            endcase
            wr  = 1'($urandom);
            uds = 1'($urandom);
            lds = 1'($urandom);
            h   = $urandom_range(12, 1);
            bus_cycle(a, wr, uds, lds, h);
            for (int j = 0; j <= h; j++) begin
                exp = model_out(a, wr, uds, lds, h, j);
                n_checks++;
                if (trace[j] !== exp) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] addr=%h wr=%b h=%0d edge %0d: got %b expected %b",
                             n, a, wr, h, j, trace[j], exp);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read_wait();
        test_ro_write();
        test_unmapped();
        test_timeout();
        test_step();
        test_run_block();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
